// File: rtl/main_controller_if.sv
// Handshake/control bundle between the multicycle MIPS control FSM and its datapath/memory.
interface main_controller_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_ctrl;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl, bus_error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl, bus_error, state
    );
endinterface

// File: rtl/main_controller.sv
// Multicycle MIPS control FSM: per-state datapath controls, alu_ctrl class, and a
// mem_ready wait counter that aborts a stalled access back to FETCH with bus_error.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4; wait for mem_ready
// DECODE    | register read, branch target into ALUOut
// MEM_ADDR  | effective address A + sign-ext imm
// MEM_RD    | data read at ALUOut; wait for mem_ready
// MEM_WB    | MDR -> rt
// MEM_WR    | data write at ALUOut; wait for mem_ready
// R_EXEC    | A op B
// R_WB      | ALUOut -> rd
// BRANCH    | compare A,B; PC <- ALUOut if zero
// JUMP      | PC <- jump target
// ADDI_EXEC | A + sign-ext imm
// ADDI_WB   | ALUOut -> rt
module main_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    main_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_CTRL_MTYPE = 2'd0;
    localparam logic [1:0] ALU_CTRL_BTYPE = 2'd1;
    localparam logic [1:0] ALU_CTRL_RTYPE = 2'd2;
    localparam logic [1:0] ALU_CTRL_JTYPE = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       r_is_lw;
    logic       w_wait_state;
    logic       w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout    = w_wait_state && !bus.mem_ready && (r_wait_cnt == TO_LAST);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_R:         w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = r_is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    w_next = bus.mem_ready ? S_MEM_WB : (w_timeout ? S_FETCH : S_MEM_RD);
            S_MEM_WR:    w_next = (bus.mem_ready || w_timeout) ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // Counter restarts on any state change, completion or abort, so it only counts
    // consecutive stalled cycles of one access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_is_lw    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!w_wait_state || bus.mem_ready || w_timeout || (w_next != r_state)) begin
                r_wait_cnt <= 8'd0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (r_state == S_DECODE) begin
                r_is_lw <= (bus.opcode == OP_LW);
            end
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.pc_src     = 2'd0;
        bus.alu_ctrl   = ALU_CTRL_JTYPE;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_ctrl  = ALU_CTRL_MTYPE;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.alu_ctrl  = ALU_CTRL_MTYPE;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_ctrl  = ALU_CTRL_MTYPE;
            end
            S_MEM_RD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = ALU_CTRL_RTYPE;
            end
            S_R_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = ALU_CTRL_BTYPE;
                bus.pc_src    = 2'd1;
                bus.pc_write  = bus.zero;
            end
            S_JUMP: begin
                bus.pc_src   = 2'd2;
                bus.pc_write = 1'b1;
            end
            S_ADDI_WB: begin
                bus.reg_write = 1'b1;
            end
            default: ;
        endcase
        // Reset must never let a strobe or enable reach the datapath.
        if (rst) begin
            bus.pc_write  = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.ir_write  = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.bus_error = w_timeout && !rst;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_main_controller.sv
// Randomized instruction streams for main_controller; expected per-cycle control words are
// queued by the stimulus side and checked by an independent negedge monitor.
module tb_main_controller;

    localparam int TO = 4;
    localparam logic [1:0] AC_M = 2'd0, AC_B = 2'd1, AC_R = 2'd2, AC_J = 2'd3;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    logic clk = 1'b0;
    logic rst = 1'b1;
    main_controller_if bus ();

    main_controller #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Control word the spec prescribes for a given state and inputs.
    function automatic logic [19:0] exp_vec(int st, bit mr, bit z, bit err, bit r);
        logic pcw, iod, mrd, mwr, irw, rd, m2r, rw, sa, be;
        logic [1:0] sb, ps, ac;
        logic [3:0] s4;
        {pcw, iod, mrd, mwr, irw, rd, m2r, rw, sa} = '0;
        sb = 2'd0; ps = 2'd0; ac = AC_J; be = err;
        s4 = 4'(st);
        case (st)
            0:  begin mrd = 1; sb = 1; ac = AC_M; irw = mr; pcw = mr; end
            1:  begin sb = 3; ac = AC_M; end
            2:  begin sa = 1; sb = 2; ac = AC_M; end
            3:  begin iod = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iod = 1; mwr = 1; end
            6:  begin sa = 1; ac = AC_R; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = AC_B; ps = 1; pcw = z; end
            9:  begin ps = 2; pcw = 1; ac = AC_J; end
            10: begin sa = 1; sb = 2; ac = AC_M; end
            11: begin rw = 1; end
            default: ;
        endcase
        if (r) begin
            {pcw, mrd, mwr, irw, rw, be} = '0;
        end
        return {s4, pcw, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, ps, ac, be};
    endfunction

    wire [19:0] act_vec = {bus.state, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                           bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                           bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_ctrl,
                           bus.bus_error};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (act_vec !== e) begin
                n_err++;
                $display("FAIL ctrl_word state%0d: got %05h expected %05h", e[19:16], act_vec, e);
            end
        end
    end

    // One clock: drive inputs, queue the expected word, advance.
    task automatic cyc(int st, bit mr, bit z, bit err, bit r, logic [5:0] op);
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.opcode    = op;
        rst           = r;
        exp_q.push_back(exp_vec(st, mr, z, err, r));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_any(int st);
        bit mr = 1'($urandom);
        bit z  = 1'($urandom);
        cyc(st, mr, z, 1'b0, 1'b0, 6'($urandom));
    endtask

    // An access that stalls nwait cycles; the TO-th stalled cycle aborts it.
    task automatic mem_phase(int st, int nwait, output bit err);
        err = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            if (i == TO - 1) begin
                cyc(st, 1'b0, 1'($urandom), 1'b1, 1'b0, 6'($urandom));
                err = 1'b1;
                return;
            end
            cyc(st, 1'b0, 1'($urandom), 1'b0, 1'b0, 6'($urandom));
        end
        cyc(st, 1'b1, 1'($urandom), 1'b0, 1'b0, 6'($urandom));
    endtask

    task automatic do_instr(logic [5:0] op, int wf, int wm, bit zb);
        bit err;
        mem_phase(0, wf, err);
        if (err) return;
        cyc(1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, op);
        case (op)
            OP_LW:   begin cyc_any(2); mem_phase(3, wm, err); if (!err) cyc_any(4); end
            OP_SW:   begin cyc_any(2); mem_phase(5, wm, err); end
            OP_R:    begin cyc_any(6); cyc_any(7); end
            OP_BEQ:  cyc(8, 1'($urandom), zb, 1'b0, 1'b0, 6'($urandom));
            OP_J:    cyc_any(9);
            OP_ADDI: begin cyc_any(10); cyc_any(11); end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        int wf, wm;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 6'h00;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00);
        do_instr(OP_R, 0, 0, 1'b0);
        do_instr(OP_LW, 0, 3, 1'b0);
        do_instr(OP_BEQ, 0, 0, 1'b1);
        do_instr(OP_BEQ, 0, 0, 1'b0);
        do_instr(OP_SW, 0, TO + 2, 1'b0);
        do_instr(6'h3f, 0, 0, 1'b0);
        do_instr(OP_J, TO + 1, 0, 1'b0);
        do_instr(OP_ADDI, TO - 1, 0, 1'b0);
        // reset dropped on an access stalled in MEM_RD
        mem_phase(0, 0, wf[0]);
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LW);
        cyc_any(2);
        cyc(3, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        cyc(3, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
        do_instr(OP_LW, 1, 1, 1'b0);
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
            do_instr(op, wf, wm, 1'($urandom));
        end
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
